io_output_bank: RTL and testbench
=================================

Name: io_output_bank

Overview:
- Parametrised memory-mapped output register bank for the sc_computer I/O space.
- Drives NUM_PORTS independent output ports, each DATA_W wide.
- Each port supports atomic write, set, clear, toggle and timed-pulse modes, selected by upper address bits.
- Provides registered readback of the effective port value so the CPU can read back what it drives.

Parameters:
- NUM_PORTS, 3: number of output ports; 1..16.
- DATA_W, 32: width of each port; 1..32. datain[DATA_W-1:0] is used.
- BASE_IDX, 6'b100000: word index (addr[7:2]) of port 0. Port i is at BASE_IDX+i. BASE_IDX+NUM_PORTS must be <= 64.
- RESET_VAL, 0: reset value of every port base register.
- PULSE_LEN, 16: number of io_clk cycles a pulse is applied; >= 1.

Ports:
- io_clk  in  1  sole clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- addr  in  32  byte address. addr[7:2] selects the port; addr[10:8] selects the mode.
- datain  in  32  write data / bit mask.
- write_io_enable  in  1  write strobe, sampled at posedge.
- read_io_enable  in  1  read strobe, sampled at posedge.
- out_port  out  NUM_PORTS*DATA_W  effective port values; port i is at [i*DATA_W +: DATA_W].
- read_data  out  32  readback value, zero-extended.
- read_valid  out  1  high for one cycle after a read.

Behaviour:
- Per-port state:
  - base register, DATA_W bits.
  - pulse mask, DATA_W bits.
  - pulse counter, clog2(PULSE_LEN+1) bits.
- Effective value: base ^ mask when counter != 0, else base. out_port is this value, produced from registers only (no combinational path from inputs).
- Decode: a port is hit when write_io_enable=1 and addr[7:2]==BASE_IDX+i for some i<NUM_PORTS. Indices in BASE_IDX+NUM_PORTS..63 are ignored. addr[31:11] and addr[1:0] are ignored.
- Modes, given by addr[10:8]; M = datain[DATA_W-1:0]:
  - 000 WRITE: base <= M.
  - 001 SET: base <= base | M.
  - 010 CLEAR: base <= base & ~M.
  - 011 TOGGLE: base <= base ^ M.
  - 100 PULSE: mask <= M, counter <= PULSE_LEN; base unchanged.
  - 101..111: reserved; no state change.
- Write latency: a write sampled at edge t is visible on out_port immediately after edge t.
- Pulse timing: out_port shows base^mask for exactly PULSE_LEN cycles, then reverts to base.
  - Counter decrements by 1 each cycle while nonzero.
  - When the counter reaches 0, mask clears to 0 on the same edge.
- Pulse interaction:
  - Any WRITE/SET/CLEAR/TOGGLE to a port with an active pulse cancels the pulse: mask <= 0, counter <= 0. The base update applies normally.
  - A PULSE write during an active pulse restarts it with the new mask and full PULSE_LEN.
  - PULSE with M=0 loads the counter; output is unchanged.
- Reads:
  - When read_io_enable=1 at edge t, read_data and read_valid are registered on edge t and valid during cycle t+1.
  - read_data returns the effective value of the addressed port as it is after edge t. The read returns the post-write value if a write is in the same cycle.
  - Unmapped index: read_data=0, read_valid=1.
  - read_valid=0 on cycles with no read. read_data holds its last value when no read occurs.
- Simultaneous read and write in one cycle are both serviced. Only one port is written per cycle.
- Reset, applied when reset=1 at a posedge:
  - Every base <= RESET_VAL, mask <= 0, counter <= 0.
  - read_data <= 0, read_valid <= 0.
  - Reset overrides any same-cycle write or read.
  - Reset during an active pulse aborts it.
- Outputs after reset: out_port = replicated RESET_VAL, read_data=0, read_valid=0.

Decomposition:
- Package io_out_pkg holds:
  - mode encodings: MODE_WRITE, MODE_SET, MODE_CLEAR, MODE_TOGGLE, MODE_PULSE (3-bit localparams);
  - the mode field position: bits 10:8;
  - the port field position: bits 7:2.
- Sub-module io_out_channel holds one port's base, mask and counter, and produces its effective value.
  - Inputs: io_clk, reset, hit, mode, data.
  - Top level instantiates NUM_PORTS channels via generate, plus the decode and the readback register.

Test Plan:
- Reset then WRITE 0x0000_00FF to port 1 (addr 0x84) -> out_port port1 = 0x000000FF next cycle; ports 0 and 2 stay 0.
- Port 0 = 0xF0F0_F0F0. SET 0x0000_000F (addr 0x180), then CLEAR 0xF000_0000 (addr 0x280), then TOGGLE 0x0000_00FF (addr 0x380) -> 0xF0F0_F0FF, then 0x00F0_F0FF, then 0x00F0_F000.
- Port 2 = 0; PULSE 0x1 (addr 0x488), PULSE_LEN=16 -> port2 = 0x1 for exactly 16 cycles, then 0x0.
- At cycle 5 of that pulse, SET 0x2 to port 2 -> next cycle port2 = 0x2; pulse cancelled; no revert glitch afterwards.
- PULSE restart: PULSE 0x1, then PULSE 0x4 after 10 cycles -> 0x4 held for 16 more cycles.
- Read port 1 with a same-cycle WRITE 0x55 -> read_valid=1, read_data=0x55 next cycle. Read unmapped addr 0xA0 -> read_data=0.
- Write reserved mode 101 -> no change.
- Assert reset during a pulse -> all ports = RESET_VAL next cycle.

Source files
------------

// File: rtl/io_out_pkg.sv
// rtl/io_out_pkg.sv - shared field positions and mode encodings for the output bank
//
// Purpose: address field layout and write-mode encodings used by
// io_output_bank and io_out_channel.
//   addr[10:8] : write mode
//   addr[7:2]  : word index selecting the port

package io_out_pkg;

    localparam logic [2:0] MODE_WRITE  = 3'b000;
    localparam logic [2:0] MODE_SET    = 3'b001;
    localparam logic [2:0] MODE_CLEAR  = 3'b010;
    localparam logic [2:0] MODE_TOGGLE = 3'b011;
    localparam logic [2:0] MODE_PULSE  = 3'b100;

    localparam int MODE_MSB = 10;
    localparam int MODE_LSB = 8;
    localparam int PORT_MSB = 7;
    localparam int PORT_LSB = 2;

    // Encodings 101..111 are reserved and must leave the port untouched.
    function automatic logic is_valid_mode(input logic [2:0] m);
        return m <= MODE_PULSE;
    endfunction

endpackage

// File: rtl/io_out_channel.sv
// rtl/io_out_channel.sv - one output port: base register, pulse mask and pulse counter
//
// Purpose: holds the state of a single output port and produces its
// effective value (base, or base ^ mask while a pulse is running).
// Ports:
//   io_clk      in   clock
//   reset       in   synchronous active-high reset
//   hit         in   this port is the write target this cycle
//   mode        in   write mode (io_out_pkg encodings)
//   data        in   write data / bit mask
//   value       out  effective value from the current registers
//   next_value  out  effective value the registers will hold after this edge

module io_out_channel
    import io_out_pkg::*;
#(
    parameter int                DATA_W    = 32,
    parameter int                PULSE_LEN = 16,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic              io_clk,
    input  logic              reset,
    input  logic              hit,
    input  logic [2:0]        mode,
    input  logic [DATA_W-1:0] data,
    output logic [DATA_W-1:0] value,
    output logic [DATA_W-1:0] next_value
);

    localparam int CNT_W = $clog2(PULSE_LEN + 1);

    logic [DATA_W-1:0] base_q, base_d;
    logic [DATA_W-1:0] mask_q, mask_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    always_comb begin
        base_d = base_q;
        mask_d = mask_q;
        cnt_d  = cnt_q;

        // Free-running pulse countdown; the mask is dropped on the final tick.
        if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                mask_d = '0;
            end
        end

        // Reserved modes are not treated as writes, so a running pulse keeps counting.
        if (hit && is_valid_mode(mode)) begin
            if (mode == MODE_PULSE) begin
                mask_d = data;
                cnt_d  = CNT_W'(PULSE_LEN);
            end else begin
                // Any base update cancels a running pulse.
                mask_d = '0;
                cnt_d  = '0;
                case (mode)
                    MODE_WRITE:  base_d = data;
                    MODE_SET:    base_d = base_q | data;
                    MODE_CLEAR:  base_d = base_q & ~data;
                    MODE_TOGGLE: base_d = base_q ^ data;
                    default:     base_d = base_q;
                endcase
            end
        end
    end

    always_ff @(posedge io_clk) begin
        if (reset) begin
            base_q <= RESET_VAL;
            mask_q <= '0;
            cnt_q  <= '0;
        end else begin
            base_q <= base_d;
            mask_q <= mask_d;
            cnt_q  <= cnt_d;
        end
    end

    assign value      = (cnt_q != '0) ? (base_q ^ mask_q) : base_q;
    assign next_value = (cnt_d != '0) ? (base_d ^ mask_d) : base_d;

endmodule

// File: rtl/io_output_bank.sv
// rtl/io_output_bank.sv - memory-mapped bank of output ports with set/clear/toggle/pulse writes
//
// Purpose: decodes CPU I/O writes onto NUM_PORTS output channels and returns
// a registered readback of the addressed port's effective value.
// Ports:
//   io_clk           in   clock
//   reset            in   synchronous active-high reset
//   addr             in   byte address; [10:8] mode, [7:2] port index
//   datain           in   write data / bit mask
//   write_io_enable  in   write strobe
//   read_io_enable   in   read strobe
//   out_port         out  effective port values, port i at [i*DATA_W +: DATA_W]
//   read_data        out  readback value, zero-extended, held between reads
//   read_valid       out  high for one cycle after a read

module io_output_bank
    import io_out_pkg::*;
#(
    parameter int          NUM_PORTS = 3,
    parameter int          DATA_W    = 32,
    parameter logic [5:0]  BASE_IDX  = 6'b100000,
    parameter logic [31:0] RESET_VAL = '0,
    parameter int          PULSE_LEN = 16
) (
    input  logic                        io_clk,
    input  logic                        reset,
    input  logic [31:0]                 addr,
    input  logic [31:0]                 datain,
    input  logic                        write_io_enable,
    input  logic                        read_io_enable,
    output logic [NUM_PORTS*DATA_W-1:0] out_port,
    output logic [31:0]                 read_data,
    output logic                        read_valid
);

    logic [5:0]        port_idx;
    logic [2:0]        mode;
    logic [DATA_W-1:0] next_vals [NUM_PORTS];
    logic [31:0]       rd_word;
    logic              unused_bits;

    assign port_idx    = addr[PORT_MSB:PORT_LSB];
    assign mode        = addr[MODE_MSB:MODE_LSB];
    assign unused_bits = ^{addr[31:11], addr[1:0], datain};

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_chan
        localparam logic [5:0] PIDX = 6'(int'(BASE_IDX) + g);
        logic hit;

        assign hit = write_io_enable && (port_idx == PIDX);

        io_out_channel #(
            .DATA_W    (DATA_W),
            .PULSE_LEN (PULSE_LEN),
            .RESET_VAL (RESET_VAL[DATA_W-1:0])
        ) u_chan (
            .io_clk     (io_clk),
            .reset      (reset),
            .hit        (hit),
            .mode       (mode),
            .data       (datain[DATA_W-1:0]),
            .value      (out_port[g*DATA_W +: DATA_W]),
            .next_value (next_vals[g])
        );
    end

    // Readback uses the post-edge value so a same-cycle write is reflected.
    always_comb begin
        rd_word = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (port_idx == 6'(int'(BASE_IDX) + i)) begin
                rd_word[DATA_W-1:0] = next_vals[i];
            end
        end
    end

    always_ff @(posedge io_clk) begin
        if (reset) begin
            read_data  <= '0;
            read_valid <= 1'b0;
        end else begin
            read_valid <= read_io_enable;
            if (read_io_enable) begin
                read_data <= rd_word;
            end
        end
    end

endmodule

// File: tb/tb_io_output_bank.sv
// tb/tb_io_output_bank.sv - self-checking bench for io_output_bank with a time-based reference model

module tb_io_output_bank;

    localparam int NP = 3;

    logic          io_clk = 1'b0;
    logic          reset = 1'b0;
    logic [31:0]   addr = '0;
    logic [31:0]   datain = '0;
    logic          write_io_enable = 1'b0;
    logic          read_io_enable = 1'b0;
    logic [NP*32-1:0] out_port;
    logic [31:0]   read_data;
    logic          read_valid;

    io_output_bank #(
        .NUM_PORTS (NP),
        .DATA_W    (32),
        .BASE_IDX  (6'b100000),
        .RESET_VAL (32'h0),
        .PULSE_LEN (16)
    ) dut (
        .io_clk          (io_clk),
        .reset           (reset),
        .addr            (addr),
        .datain          (datain),
        .write_io_enable (write_io_enable),
        .read_io_enable  (read_io_enable),
        .out_port        (out_port),
        .read_data       (read_data),
        .read_valid      (read_valid)
    );

    always #5 io_clk = ~io_clk;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    // Reference: each port is a base word plus an optional pulse described by
    // the edge count at which it expires.
    int          cyc = 0;
    logic [31:0] m_base  [NP];
    logic [31:0] m_pmask [NP];
    int          m_pend  [NP];
    logic [31:0] exp_rd = '0;
    logic        exp_rv = 1'b0;

    function automatic logic [31:0] eff(input int p);
        return (cyc < m_pend[p]) ? (m_base[p] ^ m_pmask[p]) : m_base[p];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic model_edge(input logic rs, input logic we, input logic re,
                              input logic [31:0] a, input logic [31:0] d);
        int idx;
        int p;
        cyc++;
        if (rs) begin
            for (int i = 0; i < NP; i++) begin
                m_base[i] = 32'h0;
                m_pmask[i] = 32'h0;
                m_pend[i] = 0;
            end
            exp_rd = 32'h0;
            exp_rv = 1'b0;
            return;
        end
        idx = int'(a[7:2]);
        p = idx - 32;
        if (we && p >= 0 && p < NP) begin
            case (a[10:8])
                3'd0: begin m_base[p] = d;              m_pend[p] = 0; end
                3'd1: begin m_base[p] = m_base[p] | d;  m_pend[p] = 0; end
                3'd2: begin m_base[p] = m_base[p] & ~d; m_pend[p] = 0; end
                3'd3: begin m_base[p] = m_base[p] ^ d;  m_pend[p] = 0; end
                3'd4: begin m_pmask[p] = d; m_pend[p] = cyc + 16; end
                default: ;
            endcase
        end
        exp_rv = re;
        if (re) exp_rd = (p >= 0 && p < NP) ? eff(p) : 32'h0;
    endtask

    task automatic step(input logic rs, input logic we, input logic re,
                        input logic [31:0] a, input logic [31:0] d);
        reset = rs;
        write_io_enable = we;
        read_io_enable = re;
        addr = a;
        datain = d;
        @(posedge io_clk);
        model_edge(rs, we, re, a, d);
        #1;
        reset = 1'b0;
        write_io_enable = 1'b0;
        read_io_enable = 1'b0;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    function automatic logic [31:0] port(input int p);
        return out_port[p*32 +: 32];
    endfunction

    always @(negedge io_clk) begin
        if (chk_en) begin
            for (int i = 0; i < NP; i++) chk("model_out_port", port(i), eff(i));
            chk("model_read_valid", {31'b0, read_valid}, {31'b0, exp_rv});
            chk("model_read_data", read_data, exp_rd);
        end
    end

    initial begin
        int n;
        int glitch;
        logic [31:0] a;
        logic [31:0] d;
        logic [5:0]  idx;

        for (int i = 0; i < NP; i++) begin
            m_base[i] = 32'h0;
            m_pmask[i] = 32'h0;
            m_pend[i] = 0;
        end

        step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        chk_en = 1'b1;
        for (int i = 0; i < NP; i++) chk("reset_port", port(i), 32'h0);
        chk("reset_read_valid", {31'b0, read_valid}, 32'h0);
        chk("reset_read_data", read_data, 32'h0);

        step(1'b0, 1'b1, 1'b0, 32'h84, 32'h0000_00FF);
        chk("write_port1", port(1), 32'h0000_00FF);
        chk("write_port0_untouched", port(0), 32'h0);
        chk("write_port2_untouched", port(2), 32'h0);

        step(1'b0, 1'b1, 1'b0, 32'h80, 32'hF0F0_F0F0);
        step(1'b0, 1'b1, 1'b0, 32'h180, 32'h0000_000F);
        chk("set_port0", port(0), 32'hF0F0_F0FF);
        step(1'b0, 1'b1, 1'b0, 32'h280, 32'hF000_0000);
        chk("clear_port0", port(0), 32'h00F0_F0FF);
        step(1'b0, 1'b1, 1'b0, 32'h380, 32'h0000_00FF);
        chk("toggle_port0", port(0), 32'h00F0_F000);

        // Pulse length: count cycles showing the pulsed value.
        step(1'b0, 1'b1, 1'b0, 32'h488, 32'h1);
        n = (port(2) == 32'h1) ? 1 : 0;
        for (int k = 0; k < 20; k++) begin
            idle();
            if (port(2) == 32'h1) n++;
        end
        chk("pulse_length", 32'(n), 32'd16);
        chk("pulse_revert", port(2), 32'h0);

        // Cancel by SET at the fifth pulse cycle.
        step(1'b0, 1'b1, 1'b0, 32'h488, 32'h1);
        for (int k = 0; k < 4; k++) idle();
        step(1'b0, 1'b1, 1'b0, 32'h188, 32'h2);
        chk("cancel_set", port(2), 32'h2);
        glitch = 0;
        for (int k = 0; k < 20; k++) begin
            idle();
            if (port(2) != 32'h2) glitch++;
        end
        chk("cancel_no_glitch", 32'(glitch), 32'd0);

        // Restart with a new mask after 10 cycles.
        step(1'b0, 1'b1, 1'b0, 32'h88, 32'h0);
        step(1'b0, 1'b1, 1'b0, 32'h488, 32'h1);
        for (int k = 0; k < 9; k++) idle();
        step(1'b0, 1'b1, 1'b0, 32'h488, 32'h4);
        n = (port(2) == 32'h4) ? 1 : 0;
        for (int k = 0; k < 20; k++) begin
            idle();
            if (port(2) == 32'h4) n++;
        end
        chk("restart_length", 32'(n), 32'd16);
        chk("restart_revert", port(2), 32'h0);

        step(1'b0, 1'b1, 1'b1, 32'h84, 32'h55);
        chk("read_same_cycle_valid", {31'b0, read_valid}, 32'h1);
        chk("read_same_cycle_data", read_data, 32'h55);
        idle();
        chk("read_idle_valid", {31'b0, read_valid}, 32'h0);
        chk("read_hold_data", read_data, 32'h55);
        step(1'b0, 1'b0, 1'b1, 32'hA0, 32'h0);
        chk("read_unmapped_valid", {31'b0, read_valid}, 32'h1);
        chk("read_unmapped_data", read_data, 32'h0);

        step(1'b0, 1'b1, 1'b0, 32'h584, 32'hFFFF);
        chk("reserved_mode", port(1), 32'h55);

        step(1'b0, 1'b1, 1'b0, 32'h480, 32'hFFFF);
        for (int k = 0; k < 3; k++) idle();
        step(1'b1, 1'b1, 1'b1, 32'h84, 32'h1234);
        for (int i = 0; i < NP; i++) chk("reset_in_pulse", port(i), 32'h0);
        chk("reset_in_pulse_valid", {31'b0, read_valid}, 32'h0);

        for (int k = 0; k < 3000; k++) begin
            idx = 6'(31 + $urandom_range(0, 5));
            if ($urandom_range(0, 9) == 0) idx = 6'($urandom);
            a = $urandom;
            a[10:8] = ($urandom_range(0, 3) == 0) ? 3'd4 : 3'($urandom_range(0, 7));
            a[7:2] = idx;
            d = ($urandom_range(0, 1) == 1) ? $urandom : (32'h1 << $urandom_range(0, 31));
            step($urandom_range(0, 299) == 0, $urandom_range(0, 9) < 5,
                 $urandom_range(0, 9) < 4, a, d);
        end

        @(posedge io_clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
